// File: rtl/zero_flag_unit.sv
// Zero/negative flag register with branch-condition decode and a small LIFO flag stack.
// Optional zero-run counter is enabled by defining ZERO_RUN_CNT_EN.
module zero_flag_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             data,
  input  logic                         ld,
  input  logic [2:0]                   cond,
  input  logic                         push,
  input  logic                         pop,
  output logic                         zero,
  output logic                         neg,
  output logic                         take,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty,
  output logic                         err,
  output logic [CNT_W-1:0]             run_cnt
);

  localparam int LW = $clog2(DEPTH+1);

  logic          zero_reg;
  logic          neg_reg;
  logic [LW-1:0] level_reg;
  logic          err_reg;
  logic [1:0]    stack [DEPTH];

  logic push_ok;
  logic pop_ok;
  logic misuse;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign push_ok = push && !pop && !full;
  assign pop_ok  = pop && !push && !empty;
  assign misuse  = (push && !pop && full) || (pop && !push && empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_reg  <= 1'b0;
      neg_reg   <= 1'b0;
      level_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (pop_ok) begin
        {neg_reg, zero_reg} <= stack[0];
      end else if (ld) begin
        zero_reg <= (data == '0);
        neg_reg  <= data[WIDTH-1];
      end
      if (push_ok) begin
        level_reg <= level_reg + LW'(1);
      end else if (pop_ok) begin
        level_reg <= level_reg - LW'(1);
      end
      if (misuse) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Shift-register stack: entry 0 is always the top, so no level-based indexing is needed.
  // Entries are not reset; level alone decides which ones are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack[0] <= {neg_reg, zero_reg};
      for (int i = 1; i < DEPTH; i++) begin
        stack[i] <= stack[i-1];
      end
    end else if (pop_ok) begin
      for (int i = 0; i < DEPTH-1; i++) begin
        stack[i] <= stack[i+1];
      end
    end
  end

  always_comb begin
    take = 1'b0;
    case (cond)
      3'b000:  take = zero_reg;
      3'b001:  take = !zero_reg;
      3'b010:  take = neg_reg;
      3'b011:  take = !neg_reg;
      3'b100:  take = !neg_reg && !zero_reg;
      3'b101:  take = neg_reg || zero_reg;
      3'b110:  take = 1'b1;
      default: take = 1'b0;
    endcase
  end

  assign zero  = zero_reg;
  assign neg   = neg_reg;
  assign level = level_reg;
  assign err   = err_reg;

`ifdef ZERO_RUN_CNT_EN
  logic [CNT_W-1:0] run_cnt_reg;

  // Counts every ld, including ones whose flag update is overridden by a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_reg <= '0;
    end else if (ld) begin
      if (data != '0) begin
        run_cnt_reg <= '0;
      end else if (run_cnt_reg != {CNT_W{1'b1}}) begin
        run_cnt_reg <= run_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign run_cnt = run_cnt_reg;
`else
  assign run_cnt = '0;
`endif

endmodule

// File: tb/tb_zero_flag_unit.sv
// Self-checking bench for zero_flag_unit: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_zero_flag_unit;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 2;
  localparam int LW     = $clog2(DEPTH+1);
  localparam int CNT_MX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] data;
  logic             ld;
  logic [2:0]       cond;
  logic             push;
  logic             pop;
  logic             zero;
  logic             neg;
  logic             take;
  logic [LW-1:0]    level;
  logic             full;
  logic             empty;
  logic             err;
  logic [CNT_W-1:0] run_cnt;

  int checks = 0;
  int passes = 0;

  // Behavioural model state
  logic [1:0] m_q[$];
  logic       m_zero;
  logic       m_neg;
  logic       m_err;
  int         m_cnt;

  zero_flag_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .ld(ld), .cond(cond), .push(push), .pop(pop),
    .zero(zero), .neg(neg), .take(take), .level(level), .full(full), .empty(empty),
    .err(err), .run_cnt(run_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic f_take(input logic [2:0] c, input logic z, input logic n);
    case (c)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return n;
      3'd3: return !n;
      3'd4: return !n && !z;
      3'd5: return n || z;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_zero = 0; m_neg = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic m_step(input logic [WIDTH-1:0] d, input logic l, input logic pu, input logic po);
    logic [1:0] old;
    logic [1:0] e;
    logic popped;
    old = {m_neg, m_zero};
    popped = 0;
    if (pu && !po) begin
      if (m_q.size() == DEPTH) m_err = 1;
      else m_q.push_back(old);
    end
    if (po && !pu) begin
      if (m_q.size() == 0) m_err = 1;
      else begin
        e = m_q.pop_back();
        {m_neg, m_zero} = e;
        popped = 1;
      end
    end
    if (l && !popped) begin
      m_zero = (d == 0);
      m_neg  = d[WIDTH-1];
    end
`ifdef ZERO_RUN_CNT_EN
    if (l) m_cnt = (d == 0) ? ((m_cnt < CNT_MX) ? m_cnt + 1 : CNT_MX) : 0;
`endif
  endtask

  // One clock transaction: inputs applied before the edge, outputs settled 1 ns after it.
  task automatic cyc(input logic [WIDTH-1:0] d, input logic l, input logic pu, input logic po);
    data = d; ld = l; push = pu; pop = po;
    @(posedge clk);
    m_step(d, l, pu, po);
    #1;
    ld = 0; push = 0; pop = 0;
    $display("txn ld=%0b push=%0b pop=%0b data=%h -> zero=%0b neg=%0b level=%0d err=%0b run_cnt=%0d",
             l, pu, po, d, zero, neg, level, err, run_cnt);
  endtask

  task automatic do_reset();
    rst_n = 0;
    m_reset();
    #2;
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; data = '0; ld = 0; push = 0; pop = 0; cond = 3'd0;
    m_reset();
    #3;
    checks++;
    if ({zero, neg, level, full, empty, err, run_cnt} !== {1'b0, 1'b0, LW'(0), 1'b0, 1'b1, 1'b0, CNT_W'(0)})
      $display("FAIL reset_state got z=%0b n=%0b lvl=%0d f=%0b e=%0b err=%0b cnt=%0d exp 0 0 0 0 1 0 0",
               zero, neg, level, full, empty, err, run_cnt);
    else passes++;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_flags();
    do_reset();
    cyc('0, 1, 0, 0);
    cond = 3'b000; #1;
    checks++;
    if ({zero, neg, take} !== 3'b101) $display("FAIL ld_zero got zn_take=%b exp 101", {zero, neg, take});
    else passes++;
    cond = 3'b001; #1;
    checks++;
    if (take !== 1'b0) $display("FAIL take_nz got %0b exp 0", take); else passes++;
    cyc(32'hFFFF_FFF6, 1, 0, 0);
    checks++;
    if ({zero, neg} !== 2'b01) $display("FAIL ld_neg got zn=%b exp 01", {zero, neg}); else passes++;
    cond = 3'b010; #1;
    checks++;
    if (take !== 1'b1) $display("FAIL take_neg got %0b exp 1", take); else passes++;
    cond = 3'b100; #1;
    checks++;
    if (take !== 1'b0) $display("FAIL take_gt got %0b exp 0", take); else passes++;
    cond = 3'b101; #1;
    checks++;
    if (take !== 1'b1) $display("FAIL take_le got %0b exp 1", take); else passes++;
    // Hold: no ld, flags must not move even with nonzero data on the bus
    cyc(32'h0000_0001, 0, 0, 0);
    checks++;
    if ({zero, neg} !== 2'b01) $display("FAIL hold got zn=%b exp 01", {zero, neg}); else passes++;
  endtask

  task automatic test_take_all();
    logic [WIDTH-1:0] vals [3];
    vals[0] = '0; vals[1] = 32'd9; vals[2] = 32'h8000_0000;
    for (int v = 0; v < 3; v++) begin
      cyc(vals[v], 1, 0, 0);
      for (int c = 0; c < 8; c++) begin
        cond = 3'(c); #1;
        checks++;
        if (take !== f_take(3'(c), m_zero, m_neg))
          $display("FAIL take_cond%0d val%0d got %0b exp %0b", c, v, take, f_take(3'(c), m_zero, m_neg));
        else passes++;
      end
    end
  endtask

  task automatic test_stack();
    logic [1:0] exp_f [3];
    exp_f[0] = 2'b10; exp_f[1] = 2'b00; exp_f[2] = 2'b01;
    do_reset();
    cyc('0, 1, 0, 0);           cyc('0, 0, 1, 0);
    cyc(32'd5, 1, 0, 0);        cyc('0, 0, 1, 0);
    cyc(32'hFFFF_FFFF, 1, 0, 0); cyc('0, 0, 1, 0);
    checks++;
    if (level !== LW'(3)) $display("FAIL stack_fill_level got %0d exp 3", level); else passes++;
    for (int i = 0; i < 3; i++) begin
      cyc('0, 1, 0, 1);  // ld must lose to the pop
      checks++;
      if ({neg, zero, level} !== {exp_f[i], LW'(2 - i)})
        $display("FAIL pop%0d got nz=%b lvl=%0d exp nz=%b lvl=%0d", i, {neg, zero}, level, exp_f[i], 2 - i);
      else passes++;
    end
    cyc('0, 0, 0, 1);
    checks++;
    if ({err, neg, zero, empty} !== 4'b1011)
      $display("FAIL pop_empty got err=%0b nz=%b empty=%0b exp err=1 nz=01 empty=1", err, {neg, zero}, empty);
    else passes++;
  endtask

  task automatic test_overflow();
    do_reset();
    cyc(32'd3, 1, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc('0, 0, 1, 0);
      checks++;
      if ({full, err, level} !== {(i >= 4), (i == 5), LW'((i > 4) ? 4 : i)})
        $display("FAIL push%0d got full=%0b err=%0b lvl=%0d exp full=%0b err=%0b lvl=%0d",
                 i, full, err, level, i >= 4, i == 5, (i > 4) ? 4 : i);
      else passes++;
    end
    cyc(32'hFFFF_0000, 1, 1, 1);
    checks++;
    if ({level, neg, zero} !== {LW'(4), 2'b10})
      $display("FAIL push_pop_same got lvl=%0d nz=%b exp lvl=4 nz=10", level, {neg, zero});
    else passes++;
  endtask

  task automatic test_run_cnt();
    int exp_c [5];
`ifdef ZERO_RUN_CNT_EN
    exp_c = '{1, 2, 3, 3, 3};
`else
    exp_c = '{0, 0, 0, 0, 0};
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc('0, 1, (i == 2), (i == 3));
      checks++;
      if (run_cnt !== CNT_W'(exp_c[i])) $display("FAIL run_cnt%0d got %0d exp %0d", i, run_cnt, exp_c[i]);
      else passes++;
    end
    cyc(32'd7, 1, 0, 0);
    checks++;
    if (run_cnt !== CNT_W'(0)) $display("FAIL run_cnt_clear got %0d exp 0", run_cnt); else passes++;
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc('0, 0, 0, 1);
    cyc('0, 1, 0, 0);
    cyc('0, 0, 1, 0);
    cyc('0, 0, 1, 0);
    checks++;
    if ({level, err, zero} !== {LW'(2), 2'b11}) $display("FAIL pre_reset got lvl=%0d err=%0b z=%0b exp 2 1 1", level, err, zero);
    else passes++;
    #2;
    rst_n = 0;
    m_reset();
    #1;
    checks++;
    if ({zero, neg, level, full, empty, err, run_cnt} !== {1'b0, 1'b0, LW'(0), 1'b0, 1'b1, 1'b0, CNT_W'(0)})
      $display("FAIL async_clear got z=%0b n=%0b lvl=%0d f=%0b e=%0b err=%0b cnt=%0d exp 0 0 0 0 1 0 0",
               zero, neg, level, full, empty, err, run_cnt);
    else passes++;
    #3;
    rst_n = 1;
    cyc('0, 0, 0, 1);
    checks++;
    if ({err, level} !== {1'b1, LW'(0)}) $display("FAIL post_reset_pop got err=%0b lvl=%0d exp 1 0", err, level);
    else passes++;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] d;
    logic [2:0] c;
    logic [LW+CNT_W+5:0] got, exp;
    do_reset();
    for (int n = 0; n < 250; n++) begin
      d = ($urandom_range(0, 2) == 0) ? '0 : WIDTH'($urandom);
      c = 3'($urandom_range(0, 7));
      cond = c;
      cyc(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      if (n == 150) begin
        do_reset();
      end
      got = {zero, neg, take, level, full, empty, err, run_cnt};
      exp = {m_zero, m_neg, f_take(c, m_zero, m_neg), LW'(m_q.size()), (m_q.size() == DEPTH),
             (m_q.size() == 0), m_err, CNT_W'(m_cnt)};
      checks++;
      if (got !== exp) $display("FAIL random%0d got %b exp %b", n, got, exp);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_flags();
    test_take_all();
    test_stack();
    test_overflow();
    test_run_cnt();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
